uart_tx: RTL and testbench

//  - UART transmitter: serialises one 8-bit parallel byte per request into 8N1 frames on O_rs232_txd.
//  - Frame is 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
//  - Contains its own baud divider, so it needs no external bps clock block.
//  - Sits between the CPU UART register interface (TX data / status) and the board serial pin.
//  - Companion of the UART receive path.

---
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8-bit byte to 8N1 serial frame with built-in baud divider.
// Define UART_TX_PARITY_EN to insert a parity bit (even or odd via PARITY_ODD) before the stop bit.
module uart_tx #(
    parameter int unsigned BPS_DIV    = 868,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_tx_start,
    input  logic [7:0] I_para_data,
    output logic       O_tx_ready,
    output logic       O_tx_busy,
    output logic       O_tx_done,
    output logic       O_rs232_txd
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BPS_DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`else
    localparam bit unused_parity_odd = PARITY_ODD;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_wrap = (cnt_q == BAUD_LAST);

    // Next-state and next-output logic; every bit state lasts exactly BPS_DIV cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = baud_wrap ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (I_tx_start) begin
                    state_d   = S_START;
                    shift_d   = I_para_data;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^I_para_data) ^ PARITY_ODD;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_idx_q == IDX_W'(7)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign O_rs232_txd = txd_q;
    assign O_tx_busy   = busy_q;
    assign O_tx_ready  = ready_q;
    assign O_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at BPS_DIV=16, cycle-exact serial line checks.
module tb_uart_tx;

    localparam int BPS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * BPS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] i_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       txd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .BPS_DIV    (BPS),
        .PARITY_ODD (1'b0)
    ) dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_tx_start  (i_start),
        .I_para_data (i_data),
        .O_tx_ready  (tx_ready),
        .O_tx_busy   (tx_busy),
        .O_tx_done   (tx_done),
        .O_rs232_txd (txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected line level for frame bit slot idx: start, data LSB first, [even parity], stop.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Request a byte; returns at the cycle-1 sample point (just after the accept edge).
    task automatic start_req(input logic [7:0] d);
        @(negedge clk);
        i_start = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    // Checks cycles 1..FRAME_CYC and the done cycle; optionally pokes a stray request at cycle poke.
    task automatic check_frame(input logic [7:0] d, input string tag, input int poke);
        for (int c = 1; c <= FRAME_CYC; c++) begin
            i_start = 1'b0;
            check($sformatf("%s txd c%0d", tag, c), 32'(txd), 32'(exp_bit(d, (c - 1) / BPS)));
            if ((c - 1) % BPS == 0) begin
                check($sformatf("%s busy c%0d", tag, c), 32'(tx_busy), 32'd1);
                check($sformatf("%s ready c%0d", tag, c), 32'(tx_ready), 32'd0);
                check($sformatf("%s done c%0d", tag, c), 32'(tx_done), 32'd0);
            end
            if (c == poke) begin
                i_start = 1'b1;
                i_data  = 8'h33;
            end
            @(posedge clk);
            #1;
        end
        i_start = 1'b0;
        check($sformatf("%s done_pulse", tag), 32'(tx_done), 32'd1);
        check($sformatf("%s done_ready", tag), 32'(tx_ready), 32'd1);
        check($sformatf("%s done_busy", tag), 32'(tx_busy), 32'd0);
        check($sformatf("%s done_txd", tag), 32'(txd), 32'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst txd", 32'(txd), 32'd1);
        check("rst ready", 32'(tx_ready), 32'd1);
        check("rst busy", 32'(tx_busy), 32'd0);
        check("rst done", 32'(tx_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame 0x55, then done must drop after one cycle.
        start_req(8'h55);
        check_frame(8'h55, "f55", 0);
        @(posedge clk);
        #1;
        check("f55 done_clr", 32'(tx_done), 32'd0);
        check("f55 idle_txd", 32'(txd), 32'd1);

        // Back-to-back: request in the done cycle starts the next frame immediately.
        start_req(8'h00);
        check_frame(8'h00, "f00", 0);
        i_start = 1'b1;
        i_data  = 8'hFF;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        check_frame(8'hFF, "fFF", 0);

        // Stray request with new data mid-frame is ignored and not queued.
        @(posedge clk);
        #1;
        start_req(8'h0F);
        check_frame(8'h0F, "f0F", 40);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("nofollow txd %0d", i), 32'(txd), 32'd1);
            check($sformatf("nofollow busy %0d", i), 32'(tx_busy), 32'd0);
        end

        // Asynchronous reset at frame cycle 50, then a clean 0xA5 frame.
        start_req(8'hC3);
        repeat (49) @(posedge clk);
        #1;
        check("pre_rst txd", 32'(txd), 32'(exp_bit(8'hC3, 3)));
        rst_n = 1'b0;
        #1;
        check("midrst txd", 32'(txd), 32'd1);
        check("midrst ready", 32'(tx_ready), 32'd1);
        check("midrst busy", 32'(tx_busy), 32'd0);
        check("midrst done", 32'(tx_done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_rst txd", 32'(txd), 32'd1);
        check("hold_rst ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_req(8'hA5);
        check_frame(8'hA5, "fA5", 0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 has three ones -> parity 1; 0x03 -> parity 0.
        @(posedge clk);
        #1;
        start_req(8'h07);
        check_frame(8'h07, "p07", 0);
        @(posedge clk);
        #1;
        start_req(8'h03);
        check_frame(8'h03, "p03", 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
